ser_word_rx: RTL and testbench

Serial-to-parallel word receiver. It is the receiving end of the serial bit stream that our 74194-style universal shift registers produce in shift mode. Bits arrive one per strobe and are assembled into a `WIDTH`-bit word. Each completed word is presented on a registered output with a valid/ready handshake, a one-word holding buffer, and sticky overflow detection. It sits between a serial link and CPU-side parallel logic.

---
 rtl/ser_word_rx.sv | 115 +++++++++++
 tb/tb_ser_word_rx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ser_word_rx.sv
// ser_word_rx: serial-to-parallel word receiver.
//
// Bits arrive one per ser_valid strobe and are assembled into a WIDTH-bit
// word. Each completed word goes into a one-word holding register (dout)
// that is drained with a valid/ready handshake. If a word completes while
// the holding register is full and not being drained, that word is dropped
// and the sticky overflow flag is set.
//
// Ports:
//   clk        - single clock, rising edge
//   clear      - synchronous active-high reset, overrides everything
//   ser_in     - serial data bit
//   ser_valid  - ser_in is sampled on this edge
//   sync       - frame realign, discards any partial word
//   ovf_clr    - clears the sticky overflow flag (a same-edge set wins)
//   out_ready  - consumer accepts dout on this edge
//   dout       - last completed word (holding register)
//   out_valid  - dout holds an unconsumed word
//   overflow   - sticky, a completed word was dropped
//   bit_cnt    - number of bits of the current partial word
//   busy       - a partial word is in progress (bit_cnt != 0)
//
// State | meaning
// IDLE  | bit_cnt = 0, no partial word
// RECV  | bit_cnt = 1..WIDTH-1, partial word in sreg_q
module ser_word_rx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             sync,
  input  logic             ovf_clr,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             out_valid,
  output logic             overflow,
  output logic [CW-1:0]    bit_cnt,
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_eff;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             complete, load, drop;

  always_comb begin
    // sync realigns before the incoming bit is considered, so a bit on the
    // same edge becomes bit 0 of a fresh word.
    cnt_eff  = sync ? '0 : cnt_q;
    sreg_d   = sreg_q;
    cnt_d    = cnt_eff;
    complete = 1'b0;

    if (ser_valid) begin
      if (MSB_FIRST) sreg_d = {sreg_q[WIDTH-2:0], ser_in};
      else           sreg_d = {ser_in, sreg_q[WIDTH-1:1]};
      if (cnt_eff == CW'(WIDTH - 1)) begin
        complete = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_eff + 1'b1;
      end
    end

    // A word may be loaded into a full buffer only if that buffer is being
    // drained on the same edge.
    load = complete && (!valid_q || out_ready);
    drop = complete && !load;

    dout_d = load ? sreg_d : dout_q;
    if (load)                       valid_d = 1'b1;
    else if (valid_q && out_ready)  valid_d = 1'b0;
    else                            valid_d = valid_q;

    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
    else              ovf_d = ovf_q;

    state_d = (cnt_d == '0) ? IDLE : RECV;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign dout      = dout_q;
  assign out_valid = valid_q;
  assign overflow  = ovf_q;
  assign bit_cnt   = cnt_q;
  assign busy      = (state_q == RECV);

endmodule

// File: tb/tb_ser_word_rx.sv
module tb_ser_word_rx;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       ser_in = 1'b0;
  logic       ser_valid = 1'b0;
  logic       sync = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       out_ready = 1'b0;

  logic [3:0] m_dout, l_dout;
  logic       m_valid, l_valid, m_ovf, l_ovf, m_busy, l_busy;
  logic [2:0] m_cnt, l_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] qm[$];
  logic [3:0] ql[$];

  always #5 clk = ~clk;

  ser_word_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .clear(clear), .ser_in(ser_in), .ser_valid(ser_valid),
    .sync(sync), .ovf_clr(ovf_clr), .out_ready(out_ready),
    .dout(m_dout), .out_valid(m_valid), .overflow(m_ovf),
    .bit_cnt(m_cnt), .busy(m_busy)
  );

  ser_word_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .clear(clear), .ser_in(ser_in), .ser_valid(ser_valid),
    .sync(sync), .ovf_clr(ovf_clr), .out_ready(out_ready),
    .dout(l_dout), .out_valid(l_valid), .overflow(l_ovf),
    .bit_cnt(l_cnt), .busy(l_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Words are written first-received bit first (w[3] arrives first).
  function automatic logic [3:0] rev4(input logic [3:0] w);
    return {w[0], w[1], w[2], w[3]};
  endfunction

  task automatic pushw(input logic [3:0] w);
    qm.push_back(w);
    ql.push_back(rev4(w));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic b);
    ser_valid = 1'b1;
    ser_in    = b;
    tick();
    ser_valid = 1'b0;
    ser_in    = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w, input int gap, input logic rdy_last);
    logic save_rdy;
    for (int i = 3; i >= 0; i--) begin
      if (i == 0 && rdy_last) begin
        save_rdy  = out_ready;
        out_ready = 1'b1;
        bit_in(w[i]);
        out_ready = save_rdy;
      end else begin
        bit_in(w[i]);
      end
      if (i != 0) repeat (gap) tick();
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_m_dout"},  m_dout,  4'h0);
    chk({tag, "_l_dout"},  l_dout,  4'h0);
    chk({tag, "_valid"},   {m_valid, l_valid}, 2'b00);
    chk({tag, "_ovf"},     {m_ovf, l_ovf},     2'b00);
    chk({tag, "_cnt"},     {m_cnt, l_cnt},     6'd0);
    chk({tag, "_busy"},    {m_busy, l_busy},   2'b00);
  endtask

  // Monitor: every accepted handshake must deliver the next expected word.
  always @(negedge clk) begin
    if (!clear && out_ready && m_valid) begin
      if (qm.size() == 0) chk("mon_msb_unexpected", m_dout, 4'hx);
      else                chk("mon_msb_word", m_dout, qm.pop_front());
    end
    if (!clear && out_ready && l_valid) begin
      if (ql.size() == 0) chk("mon_lsb_unexpected", l_dout, 4'hx);
      else                chk("mon_lsb_word", l_dout, ql.pop_front());
    end
  end

  initial begin
    // Reset
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    chk_reset("reset");

    // Partial word then clear discards it
    bit_in(1'b1);
    bit_in(1'b1);
    chk("partial_cnt", m_cnt, 3'd2);
    chk("partial_busy", m_busy, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_reset("midword_clear");

    // MSB/LSB first, consecutive bits, latency
    pushw(4'b1010);
    bit_in(1'b1);
    bit_in(1'b0);
    bit_in(1'b1);
    chk("lat_pre_valid", m_valid, 1'b0);
    chk("lat_pre_cnt", m_cnt, 3'd3);
    bit_in(1'b0);
    chk("lat_valid", {m_valid, l_valid}, 2'b11);
    chk("msb_1010", m_dout, 4'b1010);
    chk("lsb_1010", l_dout, 4'b0101);
    chk("idle_after_word", {m_cnt, m_busy}, 4'b0000);
    pop();
    chk("pop_valid", {m_valid, l_valid}, 2'b00);
    chk("pop_dout_kept", m_dout, 4'b1010);

    // Same word with 3 idle cycles between bits
    pushw(4'b1010);
    bit_in(1'b1);
    repeat (3) tick();
    chk("gap_cnt_hold", l_cnt, 3'd1);
    bit_in(1'b0);
    repeat (3) tick();
    bit_in(1'b1);
    repeat (3) tick();
    chk("gap_cnt3", l_cnt, 3'd3);
    bit_in(1'b0);
    chk("gap_lsb", l_dout, 4'b0101);
    chk("gap_msb", m_dout, 4'b1010);
    pop();

    // Overflow: second word dropped while first is held
    pushw(4'b1100);
    send_word(4'b1100, 0, 1'b0);
    send_word(4'b0011, 0, 1'b0);
    chk("ovf_dout_m", m_dout, 4'b1100);
    chk("ovf_dout_l", l_dout, 4'b0011);
    chk("ovf_flag", {m_ovf, l_ovf}, 2'b11);
    chk("ovf_valid", m_valid, 1'b1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", {m_ovf, l_ovf}, 2'b00);
    chk("ovf_clr_dout_held", m_dout, 4'b1100);

    // Pop and completion on the same edge
    pushw(4'b0110);
    send_word(4'b0110, 0, 1'b1);
    chk("simul_valid", {m_valid, l_valid}, 2'b11);
    chk("simul_dout", m_dout, 4'b0110);
    chk("simul_ovf", {m_ovf, l_ovf}, 2'b00);
    pop();

    // Sync without a bit returns to IDLE
    bit_in(1'b1);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk("sync_only_cnt", m_cnt, 3'd0);
    chk("sync_only_busy", m_busy, 1'b0);

    // Sync with a bit on the same edge starts a new word
    bit_in(1'b1);
    bit_in(1'b1);
    pushw(4'b0101);
    sync      = 1'b1;
    ser_valid = 1'b1;
    ser_in    = 1'b0;
    tick();
    sync      = 1'b0;
    ser_valid = 1'b0;
    chk("sync_cnt", m_cnt, 3'd1);
    chk("sync_valid_untouched", m_valid, 1'b0);
    bit_in(1'b1);
    bit_in(1'b0);
    bit_in(1'b1);
    chk("sync_msb", m_dout, 4'b0101);
    chk("sync_lsb", l_dout, 4'b1010);
    pop();

    // Back-to-back words with out_ready held high
    out_ready = 1'b1;
    pushw(4'b1001);
    pushw(4'b0111);
    send_word(4'b1001, 0, 1'b0);
    send_word(4'b0111, 0, 1'b0);
    chk("b2b_dout", m_dout, 4'b0111);
    chk("b2b_ovf", {m_ovf, l_ovf}, 2'b00);
    tick();
    out_ready = 1'b0;
    chk("b2b_drained", {m_valid, l_valid}, 2'b00);

    // Overflow set wins over ovf_clr on the same edge
    pushw(4'b0011);
    send_word(4'b0011, 0, 1'b0);
    bit_in(1'b1);
    bit_in(1'b1);
    bit_in(1'b1);
    ovf_clr = 1'b1;
    bit_in(1'b1);
    ovf_clr = 1'b0;
    chk("set_wins_ovf", {m_ovf, l_ovf}, 2'b11);
    chk("set_wins_dout", m_dout, 4'b0011);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("set_wins_clr_after", m_ovf, 1'b0);
    pop();

    // Clear while a word is held and another is partial
    send_word(4'b1000, 0, 1'b0);
    bit_in(1'b1);
    chk("pre_clear_held", {m_valid, m_cnt}, 4'b1001);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_reset("handshake_clear");
    repeat (2) tick();

    chk("queue_msb_empty", qm.size(), 0);
    chk("queue_lsb_empty", ql.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
